// File: rtl/signed_sar_search.sv
// signed_sar_search: binary-search initiator for an external signed comparator.
// Drives a trial operand to the comparator B input (A holds the unknown target),
// narrows a signed [lo, hi] window from the altb/agtb/aeqb flags, and reports the
// recovered target once aeqb is seen.
// Optional build macro: SAR_FLAGCHK_EN enables the one-hot flag consistency check
// and the err output; without it err is tied low and flags resolve by priority
// aeqb > agtb > altb (no flag set behaves like altb).
module signed_sar_search #(
    parameter int  WIDTH   = 4,
    parameter int  CMP_LAT = 0,
    localparam int STEPW   = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             altb,
    input  logic             agtb,
    input  logic             aeqb,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic [STEPW-1:0] steps,
    output logic             err
);

    // Wait counter only needs to reach CMP_LAT; keep at least one bit.
    localparam int CNTW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;
    localparam logic [CNTW-1:0] LAT_CNT = CNTW'(CMP_LAT);
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [STEPW-1:0] STEP_ONE = {{(STEPW-1){1'b0}}, 1'b1};

    // Search window bounds carry one extra bit so trial+1 / trial-1 never wrap.
    localparam logic signed [WIDTH:0] LO_INIT = {2'b11, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH:0] HI_INIT = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] ONE_X   = {{WIDTH{1'b0}}, 1'b1};
    // Midpoint of the full signed range is always -1.
    localparam logic signed [WIDTH-1:0] TRIAL_INIT = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state_r;
    logic [CNTW-1:0]          cnt_r;
    logic signed [WIDTH:0]    lo_r;
    logic signed [WIDTH:0]    hi_r;
    logic signed [WIDTH-1:0]  trial_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     found_r;
    logic signed [WIDTH-1:0]  result_r;
    logic [STEPW-1:0]         steps_r;

    logic                     sample_s;
    logic signed [WIDTH:0]    trial_ext_s;
    logic signed [WIDTH:0]    lo_nxt_s;
    logic signed [WIDTH:0]    hi_nxt_s;
    logic signed [WIDTH:0]    mid_sum_s;
    logic signed [WIDTH-1:0]  trial_nxt_s;
    logic                     exhausted_s;

    assign sample_s    = (cnt_r == LAT_CNT);
    assign trial_ext_s = (WIDTH + 1)'(trial_r);

    // Narrow the window from the flags and form the next midpoint trial.
    always_comb begin
        lo_nxt_s = lo_r;
        hi_nxt_s = hi_r;
        if (aeqb) begin
            lo_nxt_s = lo_r;
            hi_nxt_s = hi_r;
        end else if (agtb) begin
            lo_nxt_s = trial_ext_s + ONE_X;
        end else begin
            hi_nxt_s = trial_ext_s - ONE_X;
        end
        mid_sum_s   = lo_nxt_s + hi_nxt_s;
        trial_nxt_s = WIDTH'(mid_sum_s >>> 1);
        exhausted_s = (lo_nxt_s > hi_nxt_s);
    end

`ifdef SAR_FLAGCHK_EN
    logic flag_err_s;
    logic err_r;

    // A well-behaved comparator asserts exactly one flag at the sample point.
    always_comb begin
        case ({altb, agtb, aeqb})
            3'b100:  flag_err_s = 1'b0;
            3'b010:  flag_err_s = 1'b0;
            3'b001:  flag_err_s = 1'b0;
            default: flag_err_s = 1'b1;
        endcase
    end

    assign err = err_r;

    // Error flag: cleared by a new search, set on an inconsistent flag sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            err_r <= 1'b0;
        end else if ((state_r == ISSUE) && sample_s && flag_err_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Search FSM: issue a trial, wait CMP_LAT cycles, act on flags, report.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            lo_r     <= '0;
            hi_r     <= '0;
            trial_r  <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            found_r  <= 1'b0;
            result_r <= '0;
            steps_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        lo_r     <= LO_INIT;
                        hi_r     <= HI_INIT;
                        trial_r  <= TRIAL_INIT;
                        steps_r  <= '0;
                        found_r  <= 1'b0;
                        result_r <= '0;
                        cnt_r    <= '0;
                        busy_r   <= 1'b1;
                        state_r  <= ISSUE;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (!sample_s) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r   <= '0;
                        steps_r <= steps_r + STEP_ONE;
`ifdef SAR_FLAGCHK_EN
                        if (flag_err_s) begin
                            found_r  <= 1'b0;
                            result_r <= trial_r;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                            state_r  <= DONE;
                        end else
`endif
                        if (aeqb) begin
                            found_r  <= 1'b1;
                            result_r <= trial_r;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                            state_r  <= DONE;
                        end else begin
                            lo_r <= lo_nxt_s;
                            hi_r <= hi_nxt_s;
                            if (exhausted_s) begin
                                found_r <= 1'b0;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                state_r <= DONE;
                            end else begin
                                trial_r <= trial_nxt_s;
                            end
                        end
                    end
                end
                DONE: begin
                    // start is deliberately ignored here.
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign trial  = trial_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign found  = found_r;
    assign result = result_r;
    assign steps  = steps_r;

endmodule

// File: tb/tb_signed_sar_search.sv
// Scoreboard bench for signed_sar_search: two instances (W=4, CMP_LAT=0 and 2),
// each driven by a behavioural comparator model. Expected done-results are queued
// when a search is launched and popped by per-instance monitors on done.
module tb_signed_sar_search;

    typedef struct {
        int found;
        int result;
        int steps;
        int err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: combinational comparator
    logic               start0 = 1'b0;
    logic               altb0, agtb0, aeqb0;
    logic signed [3:0]  trial0, result0;
    logic               busy0, done0, found0, err0;
    logic [2:0]         steps0;
    logic signed [3:0]  target0 = 4'sd0;
    int                 mode0 = 0;

    // Instance 1: two-cycle comparator latency
    logic               start1 = 1'b0;
    logic               altb1, agtb1, aeqb1;
    logic signed [3:0]  trial1, result1;
    logic               busy1, done1, found1, err1;
    logic [2:0]         steps1;
    logic signed [3:0]  target1 = 4'sd0;
    logic [2:0]         p1 = 3'b000;
    logic [2:0]         p2 = 3'b000;

    int n_pass = 0;
    int n_chk  = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [3:0] tlog0[$];
    logic [3:0] tlog1[$];

    signed_sar_search #(.WIDTH(4), .CMP_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .altb(altb0), .agtb(agtb0), .aeqb(aeqb0),
        .trial(trial0), .busy(busy0), .done(done0), .found(found0),
        .result(result0), .steps(steps0), .err(err0)
    );

    signed_sar_search #(.WIDTH(4), .CMP_LAT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .altb(altb1), .agtb(agtb1), .aeqb(aeqb1),
        .trial(trial1), .busy(busy1), .done(done1), .found(found1),
        .result(result1), .steps(steps1), .err(err1)
    );

    // Comparator 0: mode 0 honest, 1 no flags, 2 altb and agtb both set
    always_comb begin
        altb0 = 1'b0; agtb0 = 1'b0; aeqb0 = 1'b0;
        case (mode0)
            1: begin altb0 = 1'b0; agtb0 = 1'b0; aeqb0 = 1'b0; end
            2: begin altb0 = 1'b1; agtb0 = 1'b1; aeqb0 = 1'b0; end
            default: begin
                altb0 = (target0 < trial0);
                agtb0 = (target0 > trial0);
                aeqb0 = (target0 == trial0);
            end
        endcase
    end

    // Comparator 1: honest, flags delayed two clocks
    always @(posedge clk) begin
        p1 <= {target1 < trial1, target1 > trial1, target1 == trial1};
        p2 <= p1;
    end
    assign {altb1, agtb1, aeqb1} = p2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, $signed(act), act, $signed(exp), exp);
    endtask

    // Monitor 0: log trials while busy, score results on done
    always @(negedge clk) begin
        exp_t e;
        if (busy0) tlog0.push_back(trial0);
        if (done0) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("dut0_found",  32'(found0),  32'(e.found));
                chk("dut0_result", 32'(result0), 32'(e.result));
                chk("dut0_steps",  32'(steps0),  32'(e.steps));
                chk("dut0_err",    32'(err0),    32'(e.err));
            end
        end
    end

    // Monitor 1: same for the latency instance
    always @(negedge clk) begin
        exp_t e;
        if (busy1) tlog1.push_back(trial1);
        if (done1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("dut1_found",  32'(found1),  32'(e.found));
                chk("dut1_result", 32'(result1), 32'(e.result));
                chk("dut1_steps",  32'(steps1),  32'(e.steps));
                chk("dut1_err",    32'(err1),    32'(e.err));
            end
        end
    end

    // Launch on dut0, wait (bounded) for done, then check the trial sequence.
    // tr holds expected trials as nibbles, first trial in the low nibble.
    task automatic run0(input string nm, input logic signed [3:0] tgt, input int md,
                        input int ef, input int er, input int es, input int ee,
                        input logic [31:0] tr, input int n);
        exp_t e;
        bit got;
        logic [31:0] tv;
        target0 = tgt;
        mode0 = md;
        tlog0.delete();
        e.found = ef; e.result = er; e.steps = es; e.err = ee;
        q0.push_back(e);
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done0) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        chk({nm, "_ntrials"}, 32'(tlog0.size()), 32'(n));
        tv = tr;
        for (int i = 0; i < n && i < tlog0.size(); i++)
            chk({nm, "_trial"}, 32'(tlog0[i]), 32'(tv[4*i +: 4]));
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, 32'(done0), 32'd0);
        chk({nm, "_idle_busy"}, 32'(busy0), 32'd0);
    endtask

    initial begin
        int cyc;
        bit got;
        logic [3:0] exp_tr1[4];
        repeat (3) @(negedge clk);
        // Reset values
        chk("rst_trial",  32'(trial0),  32'd0);
        chk("rst_busy",   32'(busy0),   32'd0);
        chk("rst_done",   32'(done0),   32'd0);
        chk("rst_found",  32'(found0),  32'd0);
        chk("rst_result", 32'(result0), 32'd0);
        chk("rst_steps",  32'(steps0),  32'd0);
        chk("rst_err",    32'(err0),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Honest searches: trials listed first-in-low-nibble
        run0("t5",  4'sd5,  0, 1, 5,  3, 0, 32'h0000_053F, 3);
        run0("tm8", -4'sd8, 0, 1, -8, 4, 0, 32'h0000_89BF, 4);
        run0("t7",  4'sd7,  0, 1, 7,  5, 0, 32'h0007_653F, 5);
        run0("tm1", -4'sd1, 0, 1, -1, 1, 0, 32'h0000_000F, 1);

        // Faulty comparators
`ifdef SAR_FLAGCHK_EN
        run0("noflag", 4'sd0, 1, 0, -1, 1, 1, 32'h0000_000F, 1);
        run0("bothlg", 4'sd0, 2, 0, -1, 1, 1, 32'h0000_000F, 1);
`else
        run0("noflag", 4'sd0, 1, 0, 0, 4, 0, 32'h0000_89BF, 4);
        run0("bothlg", 4'sd0, 2, 0, 0, 5, 0, 32'h0007_653F, 5);
`endif

        // Reset in the second iteration aborts with no done pulse
        target0 = 4'sd5; mode0 = 0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        @(negedge clk);
        chk("mid_trial", 32'(trial0), 32'(4'sd3));
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_trial",  32'(trial0),  32'd0);
        chk("abort_busy",   32'(busy0),   32'd0);
        chk("abort_done",   32'(done0),   32'd0);
        chk("abort_result", 32'(result0), 32'd0);
        chk("abort_steps",  32'(steps0),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run0("post_rst_tm3", -4'sd3, 0, 1, -3, 3, 0, 32'h0000_0DBF, 3);

        // start while busy and in the done cycle must be ignored
        target0 = 4'sd7; mode0 = 0;
        tlog0.delete();
        begin
            exp_t e;
            e.found = 1; e.result = 7; e.steps = 5; e.err = 0;
            q0.push_back(e);
        end
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done0) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("ign_done_seen", 32'(got), 32'd1);
        chk("ign_ntrials", 32'(tlog0.size()), 32'd5);
        start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        chk("ign_done_busy", 32'(busy0), 32'd0);
        repeat (3) @(negedge clk);
        chk("ign_busy_later", 32'(busy0),   32'd0);
        chk("ign_result",     32'(result0), 32'(4'sd7));
        chk("ign_steps",      32'(steps0),  32'd5);

        // Latency-2 instance, target 0: trials -1,3,1,0 each held 3 cycles
        target1 = 4'sd0;
        tlog1.delete();
        begin
            exp_t e;
            e.found = 1; e.result = 0; e.steps = 4; e.err = 0;
            q1.push_back(e);
        end
        exp_tr1[0] = 4'hF; exp_tr1[1] = 4'h3; exp_tr1[2] = 4'h1; exp_tr1[3] = 4'h0;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        cyc = 0;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            cyc++;
            if (done1) begin got = 1'b1; break; end
        end
        chk("lat2_done_seen", 32'(got), 32'd1);
        chk("lat2_done_cycle", 32'(cyc), 32'd12);
        chk("lat2_ntrials", 32'(tlog1.size()), 32'd12);
        for (int i = 0; i < 12 && i < tlog1.size(); i++)
            chk("lat2_trial", 32'(tlog1[i]), 32'(exp_tr1[i / 3]));
        @(negedge clk);
        chk("lat2_done_one_cycle", 32'(done1), 32'd0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
